// File: rtl/ser_lane_arbiter.sv
// Round-robin arbiter that shares one serial demux input between N_LANES source lanes.
// Optional frame watchdog is built when ARB_WATCHDOG_EN is defined.
module ser_lane_arbiter #(
    parameter int N_LANES  = 4,
    parameter int WD_TICKS = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic [N_LANES-1:0]         req,
    input  logic [N_LANES-1:0]         ser_lane,
    input  logic                       frame_done,
    output logic                       ser_out,
    output logic [N_LANES-1:0]         grant,
    output logic                       gnt_valid,
    output logic [$clog2(N_LANES)-1:0] gnt_id,
    output logic [N_LANES-1:0]         ack,
    output logic                       abort
);

    localparam int ID_W = $clog2(N_LANES);
    localparam logic [N_LANES-1:0] LANE0_OH = {{(N_LANES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_GUARD = 3'd2,
        ST_XFER  = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_LANES-1:0]  grant_q, grant_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [N_LANES-1:0]  ack_q, ack_d;
    logic                abort_q, abort_d;
    logic                win_found_s;
    logic [ID_W-1:0]     win_id_s;
    logic [ID_W-1:0]     cand_s;
    logic [ID_W-1:0]     ptr_next_s;
    logic                wd_expire_s;

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_TICKS + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog tick counter: runs only in XFER, held at zero elsewhere.
    always_comb begin
        wd_d = wd_q;
        if (state_q == ST_XFER) begin
            if (clk_en) begin
                wd_d = wd_q + WD_W'(1);
            end else begin
                wd_d = wd_q;
            end
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Expiry coincides with the WD_TICKS-th tick so a same-cycle frame_done can win.
    assign wd_expire_s = (state_q == ST_XFER) && clk_en && (wd_q == WD_W'(WD_TICKS - 1));
`else
    assign wd_expire_s = 1'b0;
`endif

    // Round-robin search of req starting at the priority pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cand_s = ID_W'((int'(ptr_q) + i) % N_LANES);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_id_s    = win_id_s;
            end
        end
    end

    assign ptr_next_s = (gnt_id_q == ID_W'(N_LANES - 1)) ? '0 : (gnt_id_q + ID_W'(1));

    // Next-state and registered-output logic of the grant sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ack_d       = '0;
        abort_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                // A request withdrawn during ARB leaves nothing to grant; fall back to IDLE.
                if (win_found_s) begin
                    state_d     = ST_GUARD;
                    grant_d     = LANE0_OH << win_id_s;
                    gnt_id_d    = win_id_s;
                    gnt_valid_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (clk_en) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            ST_XFER: begin
                if (frame_done || wd_expire_s) begin
                    state_d     = ST_REL;
                    ptr_d       = ptr_next_s;
                    grant_d     = '0;
                    gnt_valid_d = 1'b0;
                    if (frame_done) begin
                        ack_d   = grant_q;
                    end else begin
                        abort_d = 1'b1;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ack_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ack_q       <= ack_d;
            abort_q     <= abort_d;
        end
    end

    assign ser_out   = (state_q == ST_XFER) ? ser_lane[gnt_id_q] : 1'b1;
    assign grant     = grant_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign ack       = ack_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_ser_lane_arbiter.sv
// Directed bench for ser_lane_arbiter (N_LANES = 4, WD_TICKS = 31); watchdog cases run under ARB_WATCHDOG_EN.
module tb_ser_lane_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic       frame_done = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] ser_lane = 4'b1111;
    logic       ser_out;
    logic [3:0] grant;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] ack;
    logic       abort;

    int   checks_n = 0;
    int   errors_n = 0;
    logic multi_hot_seen = 1'b0;

    ser_lane_arbiter #(.N_LANES(4), .WD_TICKS(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .req        (req),
        .ser_lane   (ser_lane),
        .frame_done (frame_done),
        .ser_out    (ser_out),
        .grant      (grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .ack        (ack),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(grant) > 1) multi_hot_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] exp_grant, input int exp_gap);
        int gap = 0;
        while (!gnt_valid && gap < 12) begin
            @(negedge clk);
            gap++;
        end
        check_eq("grant_gap", 32'(gap), 32'(exp_gap));
        check_eq("grant", 32'(grant), 32'(exp_grant));
    endtask

    task automatic tick_en();
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    logic [3:0] order [5];

    initial begin
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_valid", 32'(gnt_valid), 32'h0);
        check_eq("rst_id", 32'(gnt_id), 32'h0);
        check_eq("rst_ser", 32'(ser_out), 32'h1);
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_abort", 32'(abort), 32'h0);
        rst = 1'b1;

        // Single request on lane 1
        req = 4'b0010;
        wait_grant(4'b0010, 2);
        check_eq("single_id", 32'(gnt_id), 32'h1);
        ser_lane = 4'b1101;
        #1 check_eq("guard_ser", 32'(ser_out), 32'h1);
        @(negedge clk);
        check_eq("guard_hold_ser", 32'(ser_out), 32'h1);
        tick_en();
        check_eq("xfer_ser0", 32'(ser_out), 32'h0);
        ser_lane = 4'b0010;
        #1 check_eq("xfer_ser1", 32'(ser_out), 32'h1);
        ser_lane = 4'b1101;
        #1 check_eq("xfer_ser2", 32'(ser_out), 32'h0);
        req = 4'b0000;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check_eq("single_ack", 32'(ack), 32'h2);
        check_eq("rel_grant", 32'(grant), 32'h0);
        check_eq("rel_valid", 32'(gnt_valid), 32'h0);
        check_eq("rel_ser", 32'(ser_out), 32'h1);
        @(negedge clk);
        check_eq("ack_one_clk", 32'(ack), 32'h0);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        @(negedge clk);
        check_eq("idle_done_ignored", 32'(ack), 32'h0);
        check_eq("idle_done_state", 32'(gnt_valid), 32'h0);

        // Reset asserted mid-transfer on lane 2
        ser_lane = 4'b1011;
        req = 4'b0100;
        wait_grant(4'b0100, 2);
        tick_en();
        check_eq("mid_ser_lane2", 32'(ser_out), 32'h0);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_grant", 32'(grant), 32'h0);
        check_eq("arst_valid", 32'(gnt_valid), 32'h0);
        check_eq("arst_ser", 32'(ser_out), 32'h1);
        check_eq("arst_id", 32'(gnt_id), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ser_lane = 4'b1111;

        // All lanes requesting: rotation 0,1,2,3,0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(order[i], (i == 0) ? 2 : 3);
            tick_en();
            if (i == 4) req = 4'b0000;
            frame_done = 1'b1;
            @(negedge clk);
            frame_done = 1'b0;
            check_eq("rot_ack", 32'(ack), 32'(order[i]));
        end
        repeat (2) @(negedge clk);

        // Owner drops req during the transfer
        req = 4'b1000;
        wait_grant(4'b1000, 2);
        tick_en();
        req = 4'b0001;
        ser_lane = 4'b0111;
        repeat (3) @(negedge clk);
        check_eq("drop_grant", 32'(grant), 32'h8);
        check_eq("drop_ser0", 32'(ser_out), 32'h0);
        ser_lane = 4'b1000;
        #1 check_eq("drop_ser1", 32'(ser_out), 32'h1);
        req = 4'b0000;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check_eq("drop_ack", 32'(ack), 32'h8);
        repeat (2) @(negedge clk);
        ser_lane = 4'b1111;

`ifdef ARB_WATCHDOG_EN
        // Watchdog expiry on lane 0, then frame_done racing the final tick on lane 1
        req = 4'b0001;
        wait_grant(4'b0001, 2);
        tick_en();
        req = 4'b0011;
        for (int k = 0; k < 30; k++) tick_en();
        check_eq("wd_pre_abort", 32'(abort), 32'h0);
        check_eq("wd_pre_valid", 32'(gnt_valid), 32'h1);
        tick_en();
        check_eq("wd_abort", 32'(abort), 32'h1);
        check_eq("wd_no_ack", 32'(ack), 32'h0);
        check_eq("wd_valid", 32'(gnt_valid), 32'h0);
        wait_grant(4'b0010, 3);
        check_eq("wd_abort_once", 32'(abort), 32'h0);
        req = 4'b0000;
        tick_en();
        for (int k = 0; k < 30; k++) tick_en();
        frame_done = 1'b1;
        tick_en();
        frame_done = 1'b0;
        check_eq("wd_race_ack", 32'(ack), 32'h2);
        check_eq("wd_race_abort", 32'(abort), 32'h0);
        repeat (2) @(negedge clk);
`endif

        check_eq("grant_one_hot", 32'(multi_hot_seen), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
